// File: rtl/mem_responder.sv
// mem_responder: fixed-latency single-outstanding word memory behind a valid/ready request/response pair.
// Optional byte enables via `define MEM_RESPONDER_BYTE_WRITE_EN (adds req_be_i).
module mem_responder #(
  parameter int                WIDTH   = 32,
  parameter int                DEPTH   = 64,
  parameter logic [WIDTH-1:0]  BASE    = 'h0400_0000,
  parameter int                LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_wen_i,
  input  logic [WIDTH-1:0]   req_addr_i,
  input  logic [WIDTH-1:0]   req_data_i,
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
  input  logic [WIDTH/8-1:0] req_be_i,
`endif
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [WIDTH-1:0]   resp_data_o,
  output logic               resp_err_o
);
  localparam int NB = WIDTH / 8;
  localparam int AW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             up;
  logic             wen_q;
  logic [WIDTH-1:0] addr_q, data_q;
  logic [NB-1:0]    be_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept, enter_resp, wen_c, err_c;
  logic [WIDTH-1:0] addr_c, data_c, off_c;
  logic [NB-1:0]    be_c, be_in;
  logic [IW-1:0]    idx_c;

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
  assign be_in = req_be_i;
`else
  assign be_in = '1;
`endif

  assign req_ready_o  = up && state == IDLE;
  assign resp_valid_o = state == RESP;
  assign accept       = req_valid_i && req_ready_o;
  assign enter_resp   = (LATENCY == 1) ? accept : (state == WAIT && cnt == LAST);

  // With single-cycle latency the request is serviced on its own accept edge.
  assign wen_c  = (LATENCY == 1) ? req_wen_i  : wen_q;
  assign addr_c = (LATENCY == 1) ? req_addr_i : addr_q;
  assign data_c = (LATENCY == 1) ? req_data_i : data_q;
  assign be_c   = (LATENCY == 1) ? be_in      : be_q;

  assign off_c = addr_c - BASE;
  assign idx_c = off_c[AW +: IW];
  assign err_c = |addr_c[AW-1:0] || addr_c < BASE || |off_c[WIDTH-1:AW+IW];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      up          <= 1'b0;
      resp_data_o <= '0;
      resp_err_o  <= 1'b0;
    end else begin
      up <= 1'b1;
      if (accept) begin
        wen_q  <= req_wen_i;
        addr_q <= req_addr_i;
        data_q <= req_data_i;
        be_q   <= be_in;
        cnt    <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (enter_resp) begin
        resp_err_o  <= err_c;
        resp_data_o <= (err_c || wen_c) ? '0 : mem[idx_c];
      end
      state <= enter_resp ? RESP :
               accept ? WAIT :
               (state == RESP && resp_ready_i) ? IDLE : state;
    end
  end

  // Storage is deliberately not reset; a write lands only when its response is formed.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && wen_c && !err_c)
      for (int b = 0; b < NB; b++)
        if (be_c[b]) mem[idx_c][8*b +: 8] <= data_c[8*b +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder (default build, optional byte-enable section).
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_wen_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_be_i = 4'hF;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  int          total = 0;
  int          bad = 0;

  mem_responder dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_wen_i(req_wen_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    .req_be_i(req_be_i),
`endif
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts just after a negedge; returns just after the negedge where resp_valid_o is first seen.
  task automatic issue(input string tag, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    int k;
    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_addr_i  = addr;
    req_data_i  = data;
    req_be_i    = be;
    chk({tag, ".ready_before"}, {31'd0, req_ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    req_wen_i   = 1'($urandom);
    req_addr_i  = $urandom;
    req_data_i  = $urandom;
    req_be_i    = 4'($urandom);
    chk({tag, ".ready_busy"}, {31'd0, req_ready_o}, 32'd0);
    k = 0;
    while (!resp_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, k, 32'd3);
  endtask

  task automatic finish(input string tag, input logic [31:0] data, input logic err);
    chk({tag, ".data"}, resp_data_o, data);
    chk({tag, ".err"}, {31'd0, resp_err_o}, {31'd0, err});
    resp_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, ".valid_after"}, {31'd0, resp_valid_o}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, req_ready_o}, 32'd1);
  endtask

  task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be,
                      input logic [31:0] exp_data, input logic exp_err);
    issue(tag, wen, addr, data, be);
    finish(tag, exp_data, exp_err);
  endtask

  initial begin
    int hits;
    // Reset held three cycles
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst.valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst.err", {31'd0, resp_err_o}, 32'd0);
    chk("rst.data", resp_data_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.ready_release", {31'd0, req_ready_o}, 32'd1);

    // Writes then reads
    xact("w0", 1'b1, 32'h0400_0000, 32'd11, 4'hF, 32'd0, 1'b0);
    xact("w1", 1'b1, 32'h0400_0004, 32'd22, 4'hF, 32'd0, 1'b0);
    xact("w2", 1'b1, 32'h0400_0008, 32'd33, 4'hF, 32'd0, 1'b0);
    xact("w3", 1'b1, 32'h0400_000C, 32'd44, 4'hF, 32'd0, 1'b0);
    xact("r0", 1'b0, 32'h0400_0000, 32'd0, 4'hF, 32'd11, 1'b0);
    xact("r1", 1'b0, 32'h0400_0004, 32'd0, 4'hF, 32'd22, 1'b0);
    xact("r2", 1'b0, 32'h0400_0008, 32'd0, 4'hF, 32'd33, 1'b0);
    xact("r3", 1'b0, 32'h0400_000C, 32'd0, 4'hF, 32'd44, 1'b0);

    // Backpressure: response held while a competing request is offered
    resp_ready_i = 1'b0;
    issue("bp", 1'b0, 32'h0400_0008, 32'd0, 4'hF);
    req_valid_i = 1'b1;
    req_wen_i   = 1'b1;
    req_addr_i  = 32'h0400_0000;
    req_data_i  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid_hold", {31'd0, resp_valid_o}, 32'd1);
      chk("bp.data_hold", resp_data_o, 32'd33);
      chk("bp.ready_low", {31'd0, req_ready_o}, 32'd0);
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("bp.valid_after", {31'd0, resp_valid_o}, 32'd0);
    chk("bp.ready_after", {31'd0, req_ready_o}, 32'd1);
    xact("bp.r0", 1'b0, 32'h0400_0000, 32'd0, 4'hF, 32'd11, 1'b0);

    // Error responses
    xact("e.mis", 1'b0, 32'h0400_0002, 32'd0, 4'hF, 32'd0, 1'b1);
    xact("e.low", 1'b0, 32'h03FF_FFFC, 32'd0, 4'hF, 32'd0, 1'b1);
    xact("e.high", 1'b0, 32'h0400_0100, 32'd0, 4'hF, 32'd0, 1'b1);
    xact("e.wlast", 1'b1, 32'h0400_00FC, 32'd77, 4'hF, 32'd0, 1'b0);
    xact("e.whigh", 1'b1, 32'h0400_0100, 32'd99, 4'hF, 32'd0, 1'b1);
    xact("e.rlast", 1'b0, 32'h0400_00FC, 32'd0, 4'hF, 32'd77, 1'b0);

    // Reset one cycle after a write is accepted
    req_valid_i = 1'b1;
    req_wen_i   = 1'b1;
    req_addr_i  = 32'h0400_0000;
    req_data_i  = 32'd55;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid_o) hits++;
    end
    chk("mid.no_resp", hits, 32'd0);
    xact("mid.r0", 1'b0, 32'h0400_0000, 32'd0, 4'hF, 32'd11, 1'b0);

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    xact("be.w", 1'b1, 32'h0400_0010, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
    xact("be.wp", 1'b1, 32'h0400_0010, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
    xact("be.r", 1'b0, 32'h0400_0010, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);
    xact("be.w0", 1'b1, 32'h0400_0010, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0);
    xact("be.r0", 1'b0, 32'h0400_0010, 32'd0, 4'hF, 32'h11BB_33DD, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
